// File: rtl/stopwatch_display_pkg.sv
// Shared types and constants for the stopwatch display driver: FSM states,
// seven-segment codes (gfedcba, active-low) and digit/decimal-point layout.
package stopwatch_display_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int NUM_DIGITS   = 6;
  localparam int SHIFT_CYCLES = 7;

  // Decimal points sit after the minutes and seconds pairs: MM.SS.hh
  localparam logic [NUM_DIGITS-1:0] DP_MASK = 6'b010100;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_DIGIT[0];
      4'd1:    s = SEG_DIGIT[1];
      4'd2:    s = SEG_DIGIT[2];
      4'd3:    s = SEG_DIGIT[3];
      4'd4:    s = SEG_DIGIT[4];
      4'd5:    s = SEG_DIGIT[5];
      4'd6:    s = SEG_DIGIT[6];
      4'd7:    s = SEG_DIGIT[7];
      4'd8:    s = SEG_DIGIT[8];
      4'd9:    s = SEG_DIGIT[9];
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/stopwatch_display_driver_bin2bcd.sv
// Sequential shift-add-3 converter: 7-bit binary to two BCD digits.
// start loads the operand, each shift cycle consumes one bit (MSB first).
module bin2bcd_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       shift,
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [6:0] bin_q;
  logic [7:0] bcd_q;
  logic [7:0] adj;

  always_comb begin
    adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) adj[7:4] = bcd_q[7:4] + 4'd3;
  end

  // Hundreds carry falls off the top; callers discard results above 99.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
    end else if (start) begin
      bin_q <= bin;
      bcd_q <= '0;
    end else if (shift) begin
      bcd_q <= 8'({adj, bin_q[6]});
      bin_q <= {bin_q[5:0], 1'b0};
    end
  end

  assign tens = bcd_q[7:4];
  assign ones = bcd_q[3:0];

endmodule

// File: rtl/stopwatch_display_driver.sv
// Snapshots stopwatch mins/secs/hundredths, converts to BCD every 9 cycles and
// scans a 6-digit active-low seven-segment display as MM.SS.hh.
// Optional: define LEADING_ZERO_BLANK_EN to blank a zero minutes-tens digit.
module stopwatch_display_driver
  import stopwatch_display_pkg::*;
#(
  parameter int SCAN_DIV   = 4,
  parameter int NUM_DIGITS = 6
) (
  input  logic       CLK_1kHz,
  input  logic       reset,
  input  logic [6:0] stopwatch_unit_mins,
  input  logic [5:0] stopwatch_unit_secs,
  input  logic [6:0] stopwatch_unit_decs,
  input  logic       stopwatch_overflow,
  input  logic       blank,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n,
  output logic       bcd_valid
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

  state_t     state;
  logic [2:0] shift_cnt;
  logic       mins_dash_s, decs_dash_s, ovf_s;
  logic       mins_dash_q, decs_dash_q, ovf_q;
  logic [NUM_DIGITS-1:0][3:0] disp_q;
  logic [3:0] m_t, m_o, s_t, s_o, d_t, d_o;
  logic       conv_start, conv_shift;

  assign conv_start = (state == LOAD);
  assign conv_shift = (state == SHIFT);

  bin2bcd_seq u_mins (.clk(CLK_1kHz), .reset(reset), .start(conv_start), .shift(conv_shift),
                      .bin(stopwatch_unit_mins), .tens(m_t), .ones(m_o));
  bin2bcd_seq u_secs (.clk(CLK_1kHz), .reset(reset), .start(conv_start), .shift(conv_shift),
                      .bin({1'b0, stopwatch_unit_secs}), .tens(s_t), .ones(s_o));
  bin2bcd_seq u_decs (.clk(CLK_1kHz), .reset(reset), .start(conv_start), .shift(conv_shift),
                      .bin(stopwatch_unit_decs), .tens(d_t), .ones(d_o));

  always_ff @(posedge CLK_1kHz) begin
    if (reset) begin
      state       <= LOAD;
      shift_cnt   <= '0;
      mins_dash_s <= 1'b0;
      decs_dash_s <= 1'b0;
      ovf_s       <= 1'b0;
      mins_dash_q <= 1'b0;
      decs_dash_q <= 1'b0;
      ovf_q       <= 1'b0;
      disp_q      <= '0;
      bcd_valid   <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        LOAD: begin
          mins_dash_s <= (stopwatch_unit_mins > 7'd99);
          decs_dash_s <= (stopwatch_unit_decs > 7'd99);
          ovf_s       <= stopwatch_overflow;
          shift_cnt   <= '0;
          state       <= SHIFT;
        end
        SHIFT: begin
          if (shift_cnt == 3'(SHIFT_CYCLES - 1)) state <= COMMIT;
          else shift_cnt <= shift_cnt + 3'd1;
        end
        COMMIT: begin
          disp_q      <= {m_t, m_o, s_t, s_o, d_t, d_o};
          mins_dash_q <= mins_dash_s;
          decs_dash_q <= decs_dash_s;
          ovf_q       <= ovf_s;
          bcd_valid   <= 1'b1;
          state       <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Scan outputs are computed for the slot being entered so anode, segment
  // and decimal point all switch on the same edge.
  logic [SW-1:0] slot_cnt, nxt_slot;
  logic [2:0]    idx, nxt_idx;
  logic [3:0]    cur_digit;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;
  logic [5:0]    an_nxt;

  always_comb begin
    nxt_slot = (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + SW'(1);
    nxt_idx  = idx;
    if (slot_cnt == SLOT_LAST) nxt_idx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    cur_digit = disp_q[nxt_idx];

    if (ovf_q) seg_nxt = SEG_DASH;
    else if (mins_dash_q && nxt_idx >= 3'd4) seg_nxt = SEG_DASH;
    else if (decs_dash_q && nxt_idx <= 3'd1) seg_nxt = SEG_DASH;
`ifdef LEADING_ZERO_BLANK_EN
    else if (nxt_idx == 3'd5 && cur_digit == 4'd0) seg_nxt = SEG_BLANK;
`endif
    else seg_nxt = seg_of(cur_digit);

    dp_nxt = ovf_q ? 1'b1 : ~DP_MASK[nxt_idx];
    an_nxt = (nxt_slot == '0) ? 6'b111111 : ~(6'd1 << nxt_idx);

    if (blank) begin
      seg_nxt = SEG_BLANK;
      dp_nxt  = 1'b1;
      an_nxt  = 6'b111111;
    end
  end

  always_ff @(posedge CLK_1kHz) begin
    if (reset) begin
      slot_cnt <= '0;
      idx      <= '0;
      an_n     <= 6'b111111;
      seg_n    <= 7'h7F;
      dp_n     <= 1'b1;
    end else begin
      slot_cnt <= nxt_slot;
      idx      <= nxt_idx;
      an_n     <= an_nxt;
      seg_n    <= seg_nxt;
      dp_n     <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_display_driver.sv
// Randomised bench for stopwatch_display_driver with a cycle-level reference
// model built from display arithmetic (value/10, value%10) and a snapshot queue.
module tb_stopwatch_display_driver;

  localparam int SCAN_DIV = 4;
  localparam int PERIOD   = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] mins;
  logic [5:0] secs;
  logic [6:0] decs;
  logic       ovf;
  logic       blank;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] an_n;
  logic       bcd_valid;

  stopwatch_display_driver #(.SCAN_DIV(SCAN_DIV), .NUM_DIGITS(6)) dut (
    .CLK_1kHz(clk), .reset(reset),
    .stopwatch_unit_mins(mins), .stopwatch_unit_secs(secs), .stopwatch_unit_decs(decs),
    .stopwatch_overflow(ovf), .blank(blank),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model state: snapshot queue and currently displayed values.
  logic [20:0] exp_q[$];
  int k = 0;
  int d_m = 0, d_s = 0, d_d = 0;
  bit d_ovf = 0;
  logic [6:0] seg_tab [0:9];

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
  end

  function automatic logic [6:0] exp_seg(input int pos);
    int dig;
    if (d_ovf) return 7'b0111111;
    if (pos >= 4 && d_m > 99) return 7'b0111111;
    if (pos <= 1 && d_d > 99) return 7'b0111111;
    case (pos)
      5: dig = d_m / 10;
      4: dig = d_m % 10;
      3: dig = d_s / 10;
      2: dig = d_s % 10;
      1: dig = d_d / 10;
      default: dig = d_d % 10;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (pos == 5 && dig == 0) return 7'h7F;
`endif
    return seg_tab[dig];
  endfunction

  task automatic step();
    logic c_rst, c_blank, c_ovf;
    logic [6:0] c_m, c_d;
    logic [5:0] c_s;
    logic [20:0] snap;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_v;
    int slot, pos;
    c_rst = reset; c_blank = blank; c_ovf = ovf;
    c_m = mins; c_s = secs; c_d = decs;
    @(posedge clk);
    #1;
    if (c_rst) begin
      k = 0; d_m = 0; d_s = 0; d_d = 0; d_ovf = 0;
      exp_q.delete();
      e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1; e_v = 1'b0;
    end else begin
      k++;
      slot = k % SCAN_DIV;
      pos  = (k / SCAN_DIV) % 6;
      e_an  = (slot == 0) ? 6'h3F : ~(6'd1 << pos);
      e_seg = exp_seg(pos);
      e_dp  = d_ovf ? 1'b1 : !(pos == 2 || pos == 4);
      if (c_blank) begin e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1; end
      e_v = (k % PERIOD == 0);
      if (k % PERIOD == 1) exp_q.push_back({c_ovf, c_m, c_s, c_d});
      if (k % PERIOD == 0 && exp_q.size() > 0) begin
        snap  = exp_q.pop_front();
        d_ovf = snap[20];
        d_m   = int'(snap[19:13]);
        d_s   = int'(snap[12:7]);
        d_d   = int'(snap[6:0]);
      end
    end
    check("an_n", 32'(an_n), 32'(e_an));
    check("seg_n", 32'(seg_n), 32'(e_seg));
    check("dp_n", 32'(dp_n), 32'(e_dp));
    check("bcd_valid", 32'(bcd_valid), 32'(e_v));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_time(input int m, input int s, input int d);
    mins = 7'(m); secs = 6'(s); decs = 7'(d);
  endtask

  initial begin
    reset = 1'b1; blank = 1'b0; ovf = 1'b0;
    set_time(0, 0, 0);
    run(3);
    reset = 1'b0;

    // All zero: first commit at 9 edges after release, then full scan.
    run(40);

    set_time(12, 34, 56);
    run(50);

    set_time(5, 7, 120);
    run(50);

    set_time(150, 63, 99);
    run(30);

    ovf = 1'b1;
    run(40);
    ovf = 1'b0;

    // Inputs change mid-conversion: old snapshot commits first.
    while (k % PERIOD != 0) step();
    set_time(12, 34, 56);
    while (k % PERIOD != 3) step();
    set_time(59, 59, 99);
    run(40);

    // Reset during SHIFT cycle 3, then display must read zeros until commit.
    while (k % PERIOD != 4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(20);

    blank = 1'b1;
    run(10);
    blank = 1'b0;
    run(10);

    for (int r = 0; r < 40; r++) begin
      set_time($urandom_range(0, 127), $urandom_range(0, 63), $urandom_range(0, 127));
      ovf   = ($urandom_range(0, 7) == 0);
      blank = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 15) == 0);
      step();
      reset = 1'b0;
      run($urandom_range(1, 25));
    end
    blank = 1'b0; ovf = 1'b0;
    run(30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
